uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between `N_REQ` byte producers (command echo, status reporter, debug dump) using round-robin arbitration. Accepts one byte per grant, sequences the transmitter's start/busy handshake, and detects a transmitter that never acknowledges a start. Sits between the producers and the baud-rate transmitter, clocked by the same system clock as the receiver path.

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with start-timeout detection.
// Define UART_ARB_LOCK_EN to keep a requester's multi-byte packet contiguous.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_data,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_busy,
    output logic               o_busy,
    output logic               o_err
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, win, sel;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take;
    logic          lock_q;

`ifdef UART_ARB_LOCK_EN
    logic lock_d;
    always_ff @(posedge i_clk) begin
        if (i_rst) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`else
    logic unused_last;
    assign lock_q      = 1'b0;
    assign unused_last = ^i_last;
`endif

    // Highest priority is ptr+1; ptr itself wins only when it is the sole requester.
    always_comb begin
        win = ptr_q;
        for (int i = N_REQ; i >= 1; i--)
            if (i_req[(int'(ptr_q) + i) % N_REQ]) win = IW'((int'(ptr_q) + i) % N_REQ);
    end

    assign sel  = (state_q == HOLD) ? ptr_q : win;
    assign take = !i_rst && ((state_q == IDLE) ? |i_req : (state_q == HOLD) && i_req[ptr_q]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        o_gnt   = '0;
        o_err   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        if (take) begin
            o_gnt[sel] = 1'b1;
            data_d     = i_data[8*sel +: 8];
            ptr_d      = sel;
            state_d    = START;
`ifdef UART_ARB_LOCK_EN
            lock_d     = !i_last[sel];
`endif
        end
        case (state_q)
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    o_err   = 1'b1;
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: state_d = i_tx_busy ? WAIT_DONE : (lock_q ? HOLD : IDLE);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_tx_start = (state_q == START);
    assign o_tx_data  = data_q;
    assign o_busy     = (state_q == START) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter with N_REQ=4, START_TIMEOUT=16.
module tb_uart_tx_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_req = '0;
    logic [31:0] i_data = '0;
    logic [3:0]  i_last = 4'hF;
    logic        i_tx_busy = 1'b0;
    logic [3:0]  o_gnt;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_err;
    int checks = 0;
    int passed = 0;

    uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data), .i_last(i_last),
        .o_gnt(o_gnt), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_busy(i_tx_busy), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req = '0;
        i_tx_busy = 1'b0;
        i_last = 4'hF;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    // Called right after the edge that entered START; leaves the arbiter after busy falls.
    task automatic frame(input int len);
        cyc();
        i_tx_busy = 1'b1;
        repeat (len) cyc();
        i_tx_busy = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (o_gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", o_gnt); else passed++;
        checks++; if (o_tx_start !== 1'b0) $display("FAIL reset_start got %b want 0", o_tx_start); else passed++;
        checks++; if (o_tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_tx_data); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else passed++;
        checks++; if (o_err !== 1'b0) $display("FAIL reset_err got %b want 0", o_err); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        i_req = 4'b0001;
        i_data[7:0] = 8'hA5;
        #1;
        checks++; if (o_gnt !== 4'b0001) $display("FAIL single_gnt got %b want 0001", o_gnt); else passed++;
        checks++; if (o_tx_start !== 1'b0) $display("FAIL single_start_early got %b want 0", o_tx_start); else passed++;
        cyc();
        i_req = '0;
        #1;
        checks++; if (o_gnt !== 4'b0000) $display("FAIL single_gnt_once got %b want 0000", o_gnt); else passed++;
        checks++; if (o_tx_start !== 1'b1) $display("FAIL single_start got %b want 1", o_tx_start); else passed++;
        checks++; if (o_tx_data !== 8'hA5) $display("FAIL single_data got %h want a5", o_tx_data); else passed++;
        checks++; if (o_busy !== 1'b1) $display("FAIL single_busy_start got %b want 1", o_busy); else passed++;
        cyc();
        checks++; if (o_tx_start !== 1'b0) $display("FAIL single_start_pulse got %b want 0", o_tx_start); else passed++;
        cyc();
        i_tx_busy = 1'b1;
        repeat (10) cyc();
        checks++; if (o_busy !== 1'b1) $display("FAIL single_busy_frame got %b want 1", o_busy); else passed++;
        i_tx_busy = 1'b0;
        cyc();
        #1;
        checks++; if (o_busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", o_busy); else passed++;
        checks++; if (o_err !== 1'b0) $display("FAIL single_err got %b want 0", o_err); else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] ed [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        do_reset();
        i_data = 32'h44332211;
        i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (o_gnt !== eg[k]) $display("FAIL rr_gnt[%0d] got %b want %b", k, o_gnt, eg[k]); else passed++;
            cyc();
            checks++; if (o_tx_data !== ed[k]) $display("FAIL rr_data[%0d] got %h want %h", k, o_tx_data, ed[k]); else passed++;
            checks++; if (o_tx_start !== 1'b1) $display("FAIL rr_start[%0d] got %b want 1", k, o_tx_start); else passed++;
            frame(3);
        end
        i_req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        i_req = 4'b0100;
        i_data[23:16] = 8'h5C;
        #1;
        checks++; if (o_gnt !== 4'b0100) $display("FAIL to_gnt got %b want 0100", o_gnt); else passed++;
        cyc();
        i_req = '0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            #1;
            checks++;
            if (o_err !== (k == 16)) $display("FAIL to_err[%0d] got %b want %b", k, o_err, k == 16);
            else passed++;
        end
        cyc();
        #1;
        checks++; if (o_busy !== 1'b0) $display("FAIL to_idle got %b want 0", o_busy); else passed++;
        checks++; if (o_err !== 1'b0) $display("FAIL to_err_pulse got %b want 0", o_err); else passed++;
        i_req = 4'b1100;
        #1;
        checks++; if (o_gnt !== 4'b1000) $display("FAIL to_next_gnt got %b want 1000", o_gnt); else passed++;
        cyc();
        i_req = '0;
        frame(2);
    endtask

    task automatic test_lock();
        logic [7:0] b1 [3] = '{8'hB1, 8'hB2, 8'hB3};
        logic       l1 [3] = '{1'b0, 1'b0, 1'b1};
`ifdef UART_ARB_LOCK_EN
        logic [3:0] eg [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
        logic [7:0] ed [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hA0};
`else
        logic [3:0] eg [4] = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
        logic [7:0] ed [4] = '{8'hB1, 8'hA0, 8'hB2, 8'hA0};
`endif
        int n1 = 0;
        do_reset();
        i_data[7:0] = 8'hA0;
        for (int k = 0; k < 4; k++) begin
            i_req = (k == 0) ? 4'b0010 : 4'b0011;
            i_data[15:8] = b1[n1 > 2 ? 2 : n1];
            i_last = {2'b11, l1[n1 > 2 ? 2 : n1], 1'b1};
            #1;
            checks++; if (o_gnt !== eg[k]) $display("FAIL lock_gnt[%0d] got %b want %b", k, o_gnt, eg[k]); else passed++;
            if (eg[k][1]) n1++;
            cyc();
            checks++; if (o_tx_data !== ed[k]) $display("FAIL lock_data[%0d] got %h want %h", k, o_tx_data, ed[k]); else passed++;
            i_req = '0;
            frame(2);
            #1;
            checks++; if (o_busy !== 1'b0) $display("FAIL lock_busy[%0d] got %b want 0", k, o_busy); else passed++;
        end
        i_last = 4'hF;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req = 4'b0001;
        i_data[7:0] = 8'h77;
        cyc();
        i_req = '0;
        cyc();
        i_tx_busy = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b1;
        cyc();
        #1;
        checks++; if (o_gnt !== 4'b0000) $display("FAIL mid_gnt got %b want 0000", o_gnt); else passed++;
        checks++; if (o_tx_start !== 1'b0) $display("FAIL mid_start got %b want 0", o_tx_start); else passed++;
        checks++; if (o_tx_data !== 8'h00) $display("FAIL mid_data got %h want 00", o_tx_data); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL mid_busy got %b want 0", o_busy); else passed++;
        checks++; if (o_err !== 1'b0) $display("FAIL mid_err got %b want 0", o_err); else passed++;
        i_rst = 1'b0;
        i_req = 4'b0011;
        #1;
        checks++; if (o_gnt !== 4'b0001) $display("FAIL mid_regrant got %b want 0001", o_gnt); else passed++;
        cyc();
        i_req = '0;
        frame(2);
    endtask

    task automatic test_pulse();
        do_reset();
        i_req = 4'b0001;
        cyc();
        i_req = '0;
        cyc();
        i_tx_busy = 1'b1;
        cyc();
        i_req = 4'b0010;
        #1;
        checks++; if (o_gnt !== 4'b0000) $display("FAIL pulse_gnt got %b want 0000", o_gnt); else passed++;
        cyc();
        i_req = '0;
        #1;
        checks++; if (o_tx_start !== 1'b0) $display("FAIL pulse_start got %b want 0", o_tx_start); else passed++;
        i_tx_busy = 1'b0;
        cyc();
        #1;
        checks++; if (o_gnt !== 4'b0000) $display("FAIL pulse_gnt_idle got %b want 0000", o_gnt); else passed++;
        checks++; if (o_busy !== 1'b0) $display("FAIL pulse_busy got %b want 0", o_busy); else passed++;
        cyc();
        #1;
        checks++; if (o_tx_start !== 1'b0) $display("FAIL pulse_start_late got %b want 0", o_tx_start); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_lock();
        test_reset_mid();
        test_pulse();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end
endmodule
